// File: rtl/filter_boundary_pad_if.sv
// Stream bundle for the boundary pad: raw demosaiced pixels in, zero-padded raster out.
interface filter_boundary_pad_if #(
    parameter int LEVEL_W = 12
);
    logic               iValid;
    logic [23:0]        iData;
    logic               oValid;
    logic [23:0]        oData;
    logic [15:0]        oX;
    logic [15:0]        oY;
    logic               oDone;
    logic               oOverflow;
    logic [LEVEL_W-1:0] oLevel;

    modport master (output iValid, iData,
                    input  oValid, oData, oX, oY, oDone, oOverflow, oLevel);
    modport slave  (input  iValid, iData,
                    output oValid, oData, oX, oY, oDone, oOverflow, oLevel);
endinterface

// File: rtl/filter_boundary_pad.sv
// Wraps each frame in a B-pixel zero border so the downstream kernel filter sees full support
// at every edge; input pixels queue in a FIFO while border pixels are emitted.
module filter_boundary_pad #(
    parameter int width      = 320,
    parameter int height     = 240,
    parameter int kernelSize = 7,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    filter_boundary_pad_if.slave bus
);
    localparam int B       = (kernelSize - 1) / 2;
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = ADDR_W + 1;

    localparam logic [15:0] LAST_X      = 16'(width + 2 * B - 1);
    localparam logic [15:0] LAST_Y      = 16'(height + 2 * B - 1);
    localparam logic [15:0] LAST_TOP_Y  = 16'(B - 1);
    localparam logic [15:0] LAST_LEFT_X = 16'(B - 1);
    localparam logic [15:0] LAST_DATA_X = 16'(B + width - 1);
    localparam logic [15:0] LAST_ACT_Y  = 16'(B + height - 1);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOP   = 3'd1,
        S_LEFT  = 3'd2,
        S_DATA  = 3'd3,
        S_RIGHT = 3'd4,
        S_BOT   = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [23:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [15:0]        px_q, px_d, py_q, py_d;
    logic [15:0]        ox_q, ox_d, oy_q, oy_d;
    logic [23:0]        data_q, data_d;
    logic               valid_q, valid_d, done_q, done_d, overflow_q, overflow_d;
    logic               push, pop, emit;

    // FIFO storage; deliberately not reset, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.iData;
        end
    end

    // Frame-walk FSM: px/py is the next padded position to emit
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        valid_d = 1'b0;
        data_d  = 24'd0;
        done_d  = 1'b0;
        pop     = 1'b0;
        emit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_q != {LEVEL_W{1'b0}}) state_d = S_TOP;
                else                            state_d = S_IDLE;
            end
            S_TOP: begin
                emit = 1'b1;
                if (px_q == LAST_X && py_q == LAST_TOP_Y) state_d = S_LEFT;
                else                                      state_d = S_TOP;
            end
            S_LEFT: begin
                emit = 1'b1;
                if (px_q == LAST_LEFT_X) state_d = S_DATA;
                else                     state_d = S_LEFT;
            end
            S_DATA: begin
                // An empty FIFO stalls here with counters held
                if (level_q != {LEVEL_W{1'b0}}) begin
                    emit   = 1'b1;
                    pop    = 1'b1;
                    data_d = mem_q[rd_ptr_q];
                    if (px_q == LAST_DATA_X) state_d = S_RIGHT;
                    else                     state_d = S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RIGHT: begin
                emit = 1'b1;
                if (px_q == LAST_X) begin
                    if (py_q < LAST_ACT_Y) state_d = S_LEFT;
                    else                   state_d = S_BOT;
                end else begin
                    state_d = S_RIGHT;
                end
            end
            S_BOT: begin
                emit = 1'b1;
                if (px_q == LAST_X && py_q == LAST_Y) state_d = S_DONE;
                else                                  state_d = S_BOT;
            end
            S_DONE: begin
                done_d  = 1'b1;
                px_d    = 16'd0;
                py_d    = 16'd0;
                ox_d    = 16'd0;
                oy_d    = 16'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (emit) begin
            valid_d = 1'b1;
            ox_d    = px_q;
            oy_d    = py_q;
            if (px_q == LAST_X) begin
                px_d = 16'd0;
                py_d = py_q + 16'd1;
            end else begin
                px_d = px_q + 16'd1;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_comb begin
        push       = bus.iValid && (level_q != FULL_LEVEL);
        overflow_d = overflow_q | (bus.iValid && (level_q == FULL_LEVEL));
        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        else      wr_ptr_d = wr_ptr_q;
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        else      rd_ptr_d = rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            level_q    <= {LEVEL_W{1'b0}};
            px_q       <= 16'd0;
            py_q       <= 16'd0;
            ox_q       <= 16'd0;
            oy_q       <= 16'd0;
            data_q     <= 24'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.oValid    = valid_q;
    assign bus.oData     = data_q;
    assign bus.oX        = ox_q;
    assign bus.oY        = oy_q;
    assign bus.oDone     = done_q;
    assign bus.oOverflow = overflow_q;
    assign bus.oLevel    = level_q;
endmodule
